// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, branch FSM states and helpers.
package lc3_pkg;
  localparam logic [3:0] OP_BR = 4'b0000;

  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE} branch_state_t;

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction
endpackage

// File: rtl/branch_resolver_if.sv
// Handshake/data bundle between the control FSM and the branch resolver.
interface branch_resolver_if;
  logic        Start;
  logic [15:0] IR;
  logic [15:0] PC;
  logic        N, Z, P;
  logic        Clear_Stats;
  logic        Busy;
  logic        Done;
  logic        BEN;
  logic        LD_PC;
  logic [15:0] PC_Target;
  logic [15:0] Branch_Count;
  logic [15:0] Taken_Count;

  modport master (output Start, IR, PC, N, Z, P, Clear_Stats,
                  input  Busy, Done, BEN, LD_PC, PC_Target, Branch_Count, Taken_Count);
  modport slave  (input  Start, IR, PC, N, Z, P, Clear_Stats,
                  output Busy, Done, BEN, LD_PC, PC_Target, Branch_Count, Taken_Count);
endinterface

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at all-ones; clear beats increment.
module sat_counter16 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Clr,
  input  logic        Inc,
  output logic [15:0] Count
);
  logic [15:0] r_count;

  always_ff @(posedge Clk) begin
    if (Reset || Clr)
      r_count <= '0;
    else if (Inc && (r_count != 16'hFFFF))
      r_count <= r_count + 16'd1;
  end

  assign Count = r_count;
endmodule

// File: rtl/branch_resolver.sv
// LC-3 BR evaluation: snapshot on Start, compute BEN/target, pulse Done (+LD_PC if taken).
module branch_resolver
  import lc3_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  branch_resolver_if.slave  bus
);
  branch_state_t r_state;
  logic [3:0]  r_op;
  logic [2:0]  r_cond;
  logic [8:0]  r_off9;
  logic [15:0] r_pc;
  logic [2:0]  r_nzp;
  logic        r_ben;
  logic [15:0] r_target;
  logic        r_done;
  logic        r_ld_pc;

  logic w_ben;
  logic w_br_inc;
  logic w_tk_inc;

  // cond=111 is unconditional even with no flag set (post-reset CC is 000)
  assign w_ben = (r_op == OP_BR) && ((r_cond == 3'b111) || ((r_cond & r_nzp) != 3'b000));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_cond   <= '0;
      r_off9   <= '0;
      r_pc     <= '0;
      r_nzp    <= '0;
      r_ben    <= 1'b0;
      r_target <= '0;
      r_done   <= 1'b0;
      r_ld_pc  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done  <= 1'b0;
          r_ld_pc <= 1'b0;
          if (bus.Start) begin
            r_op    <= bus.IR[15:12];
            r_cond  <= bus.IR[11:9];
            r_off9  <= bus.IR[8:0];
            r_pc    <= bus.PC;
            r_nzp   <= {bus.N, bus.Z, bus.P};
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_ben    <= w_ben;
          r_target <= r_pc + sext9(r_off9);
          // Done/LD_PC registered on entry so they are high exactly while in RESOLVE
          r_done   <= 1'b1;
          r_ld_pc  <= w_ben;
          r_state  <= RESOLVE;
        end
        RESOLVE: begin
          r_done  <= 1'b0;
          r_ld_pc <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_br_inc = (r_state == RESOLVE) && (r_op == OP_BR);
  assign w_tk_inc = (r_state == RESOLVE) && r_ben;

  sat_counter16 u_branch (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (bus.Clear_Stats),
    .Inc   (w_br_inc),
    .Count (bus.Branch_Count)
  );

  sat_counter16 u_taken (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (bus.Clear_Stats),
    .Inc   (w_tk_inc),
    .Count (bus.Taken_Count)
  );

  assign bus.Busy      = (r_state != IDLE);
  assign bus.Done      = r_done;
  assign bus.LD_PC     = r_ld_pc;
  assign bus.BEN       = r_ben;
  assign bus.PC_Target = r_target;
endmodule

// File: tb/tb_branch_resolver.sv
// Directed + random checks of branch_resolver against an arithmetic reference model.
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_br   = 0;
  int   m_tk   = 0;

  branch_resolver_if bus ();

  branch_resolver dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_br = 0;
    m_tk = 0;
  endtask

  function automatic bit model_taken(input logic [15:0] ir, input logic [2:0] nzp);
    int op, cond;
    op   = int'(ir) / 4096;
    cond = (int'(ir) / 512) % 8;
    if (op != 0) return 1'b0;
    if (cond == 7) return 1'b1;
    return ((cond & int'(nzp)) != 0);
  endfunction

  function automatic logic [15:0] model_target(input logic [15:0] pc, input logic [15:0] ir);
    int off;
    off = int'(ir) % 512;
    if (off >= 256) off = off - 512;
    return 16'((int'(pc) + off + 65536) % 65536);
  endfunction

  // One full evaluation; flags are scrambled after the Start cycle to prove snapshotting.
  task automatic run_br(input logic [15:0] ir, input logic [15:0] pc, input logic [2:0] nzp,
                        input bit clr, input string tag);
    bit          tk, isbr;
    logic [15:0] tgt;
    tk   = model_taken(ir, nzp);
    isbr = (int'(ir) / 4096) == 0;
    tgt  = model_target(pc, ir);
    bus.IR = ir;
    bus.PC = pc;
    {bus.N, bus.Z, bus.P} = nzp;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    {bus.N, bus.Z, bus.P} = 3'($urandom);
    bus.IR = 16'($urandom);
    bus.PC = 16'($urandom);
    chk({tag, ".busy_eval"}, 16'(bus.Busy), 16'd1);
    chk({tag, ".done_eval"}, 16'(bus.Done), 16'd0);
    tick();
    chk({tag, ".done"},  16'(bus.Done),  16'd1);
    chk({tag, ".ld_pc"}, 16'(bus.LD_PC), 16'(tk));
    chk({tag, ".ben"},   16'(bus.BEN),   16'(tk));
    chk({tag, ".tgt"},   bus.PC_Target,  tgt);
    bus.Clear_Stats = clr;
    tick();
    bus.Clear_Stats = 1'b0;
    if (clr) begin
      m_br = 0;
      m_tk = 0;
    end else begin
      if (isbr && m_br < 65535) m_br++;
      if (tk && m_tk < 65535) m_tk++;
    end
    chk({tag, ".done_off"}, 16'(bus.Done), 16'd0);
    chk({tag, ".busy_off"}, 16'(bus.Busy), 16'd0);
    chk({tag, ".brcnt"}, bus.Branch_Count, 16'(m_br));
    chk({tag, ".tkcnt"}, bus.Taken_Count,  16'(m_tk));
  endtask

  initial begin
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.IR = '0;
    bus.PC = '0;
    {bus.N, bus.Z, bus.P} = 3'b000;
    bus.Clear_Stats = 1'b0;

    // Reset and idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("idle.busy", 16'(bus.Busy), 16'd0);
      tick();
    end
    chk("rst.done",  16'(bus.Done),  16'd0);
    chk("rst.ld_pc", 16'(bus.LD_PC), 16'd0);
    chk("rst.ben",   16'(bus.BEN),   16'd0);
    chk("rst.tgt",   bus.PC_Target,    16'h0000);
    chk("rst.brcnt", bus.Branch_Count, 16'h0000);
    chk("rst.tkcnt", bus.Taken_Count,  16'h0000);

    // BRnzp straight after reset with CC=000 is taken
    run_br(16'h0E00, 16'h1234, 3'b000, 1'b0, "brnzp0");
    do_reset();

    // Directed cases
    run_br(16'h0405, 16'h3001, 3'b010, 1'b0, "brz");
    chk("brz.tgt_const", dut.bus.PC_Target, 16'h3006);
    run_br(16'h09FE, 16'h3000, 3'b001, 1'b0, "brn_nt");
    chk("brn.tgt_const", bus.PC_Target, 16'h2FFE);
    run_br(16'h09FF, 16'h0000, 3'b001, 1'b0, "wrap");
    chk("wrap.tgt_const", bus.PC_Target, 16'hFFFF);
    run_br(16'h1021, 16'h3000, 3'b111, 1'b0, "add");
    run_br(16'h0000, 16'h3000, 3'b111, 1'b0, "nop");

    // Start held through EVAL/RESOLVE with flags flipped: second Start ignored
    bus.IR = 16'h0203; bus.PC = 16'h4000;
    {bus.N, bus.Z, bus.P} = 3'b001;
    bus.Start = 1'b1;
    tick();
    {bus.N, bus.Z, bus.P} = 3'b100;
    tick();
    chk("hold.ben", 16'(bus.BEN), 16'd1);
    chk("hold.tgt", bus.PC_Target, 16'h4003);
    bus.Start = 1'b0;
    tick();
    m_br++; m_tk++;
    chk("hold.idle", 16'(bus.Busy), 16'd0);
    tick();
    chk("hold.noreq", 16'(bus.Busy), 16'd0);
    chk("hold.brcnt", bus.Branch_Count, 16'(m_br));

    // Reset during EVAL: no Done, back to idle
    bus.IR = 16'h0E01; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; m_br = 0; m_tk = 0;
    chk("rstev.busy", 16'(bus.Busy), 16'd0);
    chk("rstev.done", 16'(bus.Done), 16'd0);
    tick();
    chk("rstev.done2", 16'(bus.Done), 16'd0);
    chk("rstev.brcnt", bus.Branch_Count, 16'd0);

    // Reset during RESOLVE: no counter increment
    run_br(16'h0E01, 16'h0100, 3'b000, 1'b0, "pre");
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; m_br = 0; m_tk = 0;
    chk("rstrs.busy",  16'(bus.Busy), 16'd0);
    chk("rstrs.done",  16'(bus.Done), 16'd0);
    chk("rstrs.brcnt", bus.Branch_Count, 16'd0);
    chk("rstrs.tkcnt", bus.Taken_Count,  16'd0);

    // Saturation of Taken_Count
    force dut.u_taken.r_count = 16'hFFFE;
    #1;
    release dut.u_taken.r_count;
    m_tk = 65534;
    run_br(16'h0E10, 16'h0200, 3'b010, 1'b0, "sat1");
    run_br(16'h0E10, 16'h0200, 3'b010, 1'b0, "sat2");
    chk("sat.hold", bus.Taken_Count, 16'hFFFF);

    // Clear_Stats coincident with an increment
    run_br(16'h0E10, 16'h0200, 3'b010, 1'b1, "clr");

    // Random evaluations
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      if ($urandom_range(3) != 0) ir = ir & 16'h0FFF;
      run_br(ir, 16'($urandom), 3'($urandom), ($urandom_range(9) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
